// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the sequential single-MAC FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } fir_state_e;

    function automatic int fir_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Wide enough that TAPS products of most-negative operands cannot overflow.
    function automatic int fir_aw(input int dw, input int cw, input int taps);
        return dw + cw + fir_clog2(taps);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate; clear takes priority over enable.
module fir_mac_unit #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int AW = 36
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [AW-1:0] acc_o
);

    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_q;
    logic signed [AW-1:0]    acc_d;

    always_comb begin
        prod  = (DW+CW)'(a_i) * (DW+CW)'(b_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(AW-DW-CW){prod[DW+CW-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR: one tap per clock through a single MAC, loadable
// coefficient bank, circular delay line, valid/ready on both sides.
module fir_seq_mac
    import fir_pkg::*;
#(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 16,
    parameter int AW   = fir_aw(DW, CW, TAPS)
) (
    input  logic                         clk,
    input  logic                         rest,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DW-1:0]         in_data,
    input  logic                         coef_we,
    input  logic [fir_clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [CW-1:0]         coef_data,
    output logic                         coef_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [AW-1:0]         out_data
);

    localparam int PW = fir_clog2(TAPS);
    localparam int KW = fir_clog2(TAPS + 1);

    fir_state_e state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [KW-1:0] k_q, k_d;
    logic          out_valid_q, out_valid_d;
    logic signed [AW-1:0] out_data_q, out_data_d;

    logic signed [DW-1:0] dline_q [TAPS];
    logic signed [CW-1:0] coef_q  [TAPS];

    logic accept;
    logic coef_wr;
    logic mac_clr;
    logic mac_en;
    logic signed [AW-1:0] acc;

    assign coef_ready = (state_q == IDLE);
    assign in_ready   = (state_q == IDLE) && !coef_we;
    assign accept     = in_valid && in_ready;
    assign coef_wr    = coef_we && coef_ready && (int'(coef_addr) < TAPS);

    fir_mac_unit #(
        .DW (DW),
        .CW (CW),
        .AW (AW)
    ) u_mac (
        .clk   (clk),
        .rst_i (rest),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (dline_q[rd_q]),
        .b_i   (coef_q[PW'(k_q)]),
        .acc_o (acc)
    );

    // k runs 0..TAPS-1 accumulating; the k==TAPS cycle only publishes acc.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_d        = rd_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        mac_clr     = 1'b0;
        mac_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = MAC;
                    mac_clr = 1'b1;
                    k_d     = '0;
                    rd_d    = wr_ptr_q;
                end
            end
            MAC: begin
                if (k_q == KW'(TAPS)) begin
                    state_d     = HOLD;
                    out_data_d  = acc;
                    out_valid_d = 1'b1;
                    wr_ptr_d    = (wr_ptr_q == PW'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
                end else begin
                    mac_en = 1'b1;
                    k_d    = k_q + 1'b1;
                    rd_d   = (rd_q == '0) ? PW'(TAPS - 1) : rd_q - 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rest) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_q        <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                dline_q[i] <= '0;
                coef_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_q        <= rd_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            if (coef_wr) coef_q[coef_addr] <= coef_data;
            if (accept)  dline_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
